// File: rtl/mult_share_ctrl_pkg.sv
// mult_pkg: shared constants and types for the shift-add multiplier controller.
//   WIDTH_DEF : default operand width
//   PROD_W_DEF: default product width (2*WIDTH_DEF)
//   prod_w()  : product width for an arbitrary operand width
//   state_t   : controller state encoding (IDLE/LOAD/CALC/DONE)
package mult_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int PROD_W_DEF = 2 * WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/mult_share_ctrl_if.sv
// mult_share_ctrl_if: requester handshakes plus the datapath control/feedback
// bundle of the shared multiplier.
//   slave  : controller view (takes requests and datapath feedback, drives
//            acks, result, grant, busy, operands and datapath controls)
//   master : requester/datapath view (the mirror image)
// iProd is the value the datapath product register will take at the coming
// edge (register plus this cycle's add term), so it is final in the last
// CALC cycle.
interface mult_share_ctrl_if
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    localparam int PW = prod_w(WIDTH);

    logic             iValid_Data0, iValid_Data1;
    logic [WIDTH-1:0] iData_A0, iData_B0, iData_A1, iData_B1;
    logic             oAck0, oAck1;
    logic [PW-1:0]    oProduct;
    logic             oGrant;
    logic             oBusy;
    logic [WIDTH-1:0] oData_A, oData_B;
    logic             oA_Sel, oB_Sel, oProduct_Sel, oAdd_Sel, oShift;
    logic             iLSB;
    logic [PW-1:0]    iProd;

    modport slave (
        input  iValid_Data0, iValid_Data1, iData_A0, iData_B0, iData_A1, iData_B1,
        input  iLSB, iProd,
        output oAck0, oAck1, oProduct, oGrant, oBusy, oData_A, oData_B,
        output oA_Sel, oB_Sel, oProduct_Sel, oAdd_Sel, oShift
    );

    modport master (
        output iValid_Data0, iValid_Data1, iData_A0, iData_B0, iData_A1, iData_B1,
        output iLSB, iProd,
        input  oAck0, oAck1, oProduct, oGrant, oBusy, oData_A, oData_B,
        input  oA_Sel, oB_Sel, oProduct_Sel, oAdd_Sel, oShift
    );

endinterface

// File: rtl/mult_share_ctrl_arb.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req[1:0]   : request lines
//   update     : strobe to record 'served' as the last requester served
//   served     : index of the requester just served
//   grant      : winning index (combinational)
// The stored pointer names the requester favoured on a tie; it resets to 0
// and flips away from whoever was just served.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       grant
);
    logic fav;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fav <= 1'b0;
        else if (update)
            fav <= ~served;
    end

    assign grant = (&req) ? fav : req[1];

endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: sequencer and two-port round-robin arbiter for a shared
// shift-add multiplier datapath.
//   Clock : rising-edge clock
//   Reset : async active-low reset
//   bus   : requester handshakes, result, grant/busy, operand mux and
//           datapath controls (see mult_share_ctrl_if)
// IDLE picks a winner, LOAD loads A/B and clears the product, CALC runs
// WIDTH shift/add iterations, DONE holds the ack until the owner drops valid.
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    mult_share_ctrl_if.slave bus
);
    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       req;
    logic             arb_grant;
    logic             last_iter;
    logic             owner_valid;

    assign req         = {bus.iValid_Data1, bus.iValid_Data0};
    assign last_iter   = (state == CALC) && (cnt == LAST);
    assign owner_valid = bus.oGrant ? bus.iValid_Data1 : bus.iValid_Data0;

    // Pointer moves on the edge that enters DONE.
    rr_arbiter2 u_arb (
        .clk    (Clock),
        .rst_n  (Reset),
        .req    (req),
        .update (last_iter),
        .served (bus.oGrant),
        .grant  (arb_grant)
    );

    // Add must track the live B LSB, so it is not registered.
    assign bus.oAdd_Sel = (state == CALC) && bus.iLSB;

    // Operands are gated by busy so the mux reads zero while idle/in reset.
    assign bus.oData_A = bus.oBusy ? (bus.oGrant ? bus.iData_A1 : bus.iData_A0) : '0;
    assign bus.oData_B = bus.oBusy ? (bus.oGrant ? bus.iData_B1 : bus.iData_B0) : '0;

    // Registered controls are set for the state being entered.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.oGrant       <= 1'b0;
            bus.oBusy        <= 1'b0;
            bus.oProduct     <= '0;
            bus.oAck0        <= 1'b0;
            bus.oAck1        <= 1'b0;
            bus.oA_Sel       <= 1'b0;
            bus.oB_Sel       <= 1'b0;
            bus.oProduct_Sel <= 1'b0;
            bus.oShift       <= 1'b0;
        end else begin
            bus.oAck0        <= 1'b0;
            bus.oAck1        <= 1'b0;
            bus.oA_Sel       <= 1'b0;
            bus.oB_Sel       <= 1'b0;
            bus.oProduct_Sel <= 1'b0;
            bus.oShift       <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= LOAD;
                        bus.oGrant <= arb_grant;
                        bus.oBusy  <= 1'b1;
                        bus.oA_Sel <= 1'b1;
                        bus.oB_Sel <= 1'b1;
                    end
                end
                LOAD: begin
                    state            <= CALC;
                    cnt              <= '0;
                    bus.oShift       <= 1'b1;
                    bus.oProduct_Sel <= 1'b1;
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        state        <= DONE;
                        bus.oProduct <= bus.iProd;
                        bus.oAck0    <= ~bus.oGrant;
                        bus.oAck1    <= bus.oGrant;
                    end else begin
                        bus.oShift       <= 1'b1;
                        bus.oProduct_Sel <= 1'b1;
                    end
                end
                DONE: begin
                    if (!owner_valid) begin
                        state     <= IDLE;
                        bus.oBusy <= 1'b0;
                    end else begin
                        bus.oAck0 <= ~bus.oGrant;
                        bus.oAck1 <= bus.oGrant;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: directed + randomized bench for mult_share_ctrl with a
// behavioural shift-add datapath and a product/arbitration reference model.
module tb_mult_share_ctrl;
    import mult_pkg::*;

    logic Clock;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;
    int   add_pulses = 0;

    mult_share_ctrl_if #(.WIDTH(32)) bus ();

    mult_share_ctrl #(.WIDTH(32)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural datapath: A shifts left, B right, product accumulates.
    logic [63:0] dp_a, dp_prod;
    logic [31:0] dp_b;
    assign bus.iLSB  = dp_b[0];
    assign bus.iProd = dp_prod + (bus.oAdd_Sel ? dp_a : 64'd0);

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            dp_a    <= '0;
            dp_b    <= '0;
            dp_prod <= '0;
        end else begin
            if (bus.oA_Sel)      dp_a <= {32'd0, bus.oData_A};
            else if (bus.oShift) dp_a <= dp_a << 1;
            if (bus.oB_Sel)      dp_b <= bus.oData_B;
            else if (bus.oShift) dp_b <= dp_b >> 1;
            dp_prod <= bus.oProduct_Sel ? bus.iProd : 64'd0;
        end
    end

    always @(posedge Clock)
        if (Reset && bus.oAdd_Sel) add_pulses <= add_pulses + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int r, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin
            bus.iValid_Data0 = v; bus.iData_A0 = a; bus.iData_B0 = b;
        end else begin
            bus.iValid_Data1 = v; bus.iData_A1 = a; bus.iData_B1 = b;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_prod"}, bus.oProduct, 64'd0);
        chk({tag, "_ctrl"}, 64'({bus.oAck0, bus.oAck1, bus.oGrant, bus.oBusy, bus.oA_Sel,
                                 bus.oB_Sel, bus.oProduct_Sel, bus.oAdd_Sel, bus.oShift}), 64'd0);
        chk({tag, "_data"}, {bus.oData_A, bus.oData_B}, 64'd0);
    endtask

    // Waits (bounded) for the ack of requester r, counting falling edges.
    task automatic wait_ack(input int r, input string tag, inout int cyc);
        int n;
        n = 0;
        while (((r == 0) ? bus.oAck0 : bus.oAck1) !== 1'b1 && n < 200) begin
            @(negedge Clock);
            n++;
            cyc++;
        end
        chk(tag, (r == 0) ? bus.oAck0 : bus.oAck1, 1'b1);
    endtask

    // One complete operation from an idle controller, four-phase handshake.
    task automatic single_op(input int r, input logic [31:0] a, input logic [31:0] b, input string tag);
        int cyc;
        int a0;
        cyc = 0;
        @(negedge Clock);
        drive(r, 1'b1, a, b);
        a0 = add_pulses;
        wait_ack(r, {tag, "_ack"}, cyc);
        chk({tag, "_lat"},   cyc, 34);
        chk({tag, "_prod"},  bus.oProduct, 64'(a) * 64'(b));
        chk({tag, "_grant"}, bus.oGrant, 64'(r));
        chk({tag, "_xack"},  (r == 0) ? bus.oAck1 : bus.oAck0, 1'b0);
        chk({tag, "_adds"},  add_pulses - a0, $countones(b));
        drive(r, 1'b0, a, b);
        @(negedge Clock);
        chk({tag, "_ackdrop"}, {bus.oAck0, bus.oAck1}, 2'b00);
        chk({tag, "_idle"},    bus.oBusy, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic        v   [2];
    int          fav, w, n, cyc, acks;
    logic [31:0] a, b;

    initial begin
        Reset = 1'b0;
        bus.iValid_Data0 = 1'b0; bus.iValid_Data1 = 1'b0;
        bus.iData_A0 = 32'hDEADBEEF; bus.iData_B0 = 32'h12345678;
        bus.iData_A1 = 32'hCAFEF00D; bus.iData_B1 = 32'h87654321;
        repeat (3) @(negedge Clock);
        check_reset_outputs("reset");
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        // Single request.
        single_op(0, 32'd10, 32'd16, "single");

        // Simultaneous requests right after reset: 0 first, then 1.
        pulse_reset();
        drive(0, 1'b1, 32'd10, 32'd16);
        drive(1, 1'b1, 32'd7, 32'd3);
        cyc = 0;
        wait_ack(0, "sim0_ack", cyc);
        chk("sim0_lat",   cyc, 34);
        chk("sim0_prod",  bus.oProduct, 64'd160);
        chk("sim0_grant", bus.oGrant, 1'b0);
        chk("sim0_xack",  bus.oAck1, 1'b0);
        drive(0, 1'b0, 32'd10, 32'd16);
        cyc = 0;
        wait_ack(1, "sim1_ack", cyc);
        chk("sim1_lat",   cyc, 35);
        chk("sim1_prod",  bus.oProduct, 64'd21);
        chk("sim1_grant", bus.oGrant, 1'b1);
        chk("sim1_xack",  bus.oAck0, 1'b0);
        drive(1, 1'b0, 32'd7, 32'd3);
        @(negedge Clock);

        // Fairness: the served requester re-requests at once while the other waits.
        pulse_reset();
        fav = 0;
        for (int r = 0; r < 2; r++) begin
            ra[r] = $urandom; rb[r] = $urandom; v[r] = 1'b1;
            drive(r, 1'b1, ra[r], rb[r]);
        end
        for (int k = 0; k < 5; k++) begin
            w = (v[0] && v[1]) ? fav : (v[1] ? 1 : 0);
            n = 0;
            while (!(bus.oAck0 || bus.oAck1) && n < 200) begin
                @(negedge Clock);
                n++;
            end
            chk("fair_ack_any", bus.oAck0 | bus.oAck1, 1'b1);
            chk("fair_who",     {bus.oAck1, bus.oAck0}, (w == 1) ? 2'b10 : 2'b01);
            chk("fair_grant",   bus.oGrant, 64'(w));
            chk("fair_prod",    bus.oProduct, 64'(ra[w]) * 64'(rb[w]));
            fav = 1 - w;
            v[w] = 1'b0;
            drive(w, 1'b0, ra[w], rb[w]);
            @(negedge Clock);
            if (k < 3) begin
                ra[w] = $urandom; rb[w] = $urandom; v[w] = 1'b1;
                drive(w, 1'b1, ra[w], rb[w]);
            end
        end
        chk("fair_idle", bus.oBusy, 1'b0);

        // Corner operands.
        single_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, "ones");
        single_op(1, 32'd0, 32'h12345678, "zero");

        // Randomized operations.
        for (int k = 0; k < 4; k++) begin
            single_op(int'($urandom_range(1, 0)), $urandom, $urandom, "rand");
        end

        // Reset at CALC iteration 10 (a nonzero result is already held).
        single_op(1, 32'd3, 32'd9, "prerst");
        @(negedge Clock);
        drive(0, 1'b1, $urandom, $urandom);
        repeat (12) @(negedge Clock);
        chk("midrst_busy_before", bus.oBusy, 1'b1);
        Reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        drive(0, 1'b0, 32'd0, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        acks = 0;
        repeat (40) begin
            @(negedge Clock);
            if (bus.oAck0 || bus.oAck1) acks++;
        end
        chk("midrst_noack", acks, 0);
        single_op(0, 32'd5, 32'd5, "postrst");

        // Requester 1 drops valid mid-CALC.
        a = $urandom; b = $urandom;
        @(negedge Clock);
        drive(1, 1'b1, a, b);
        cyc = 0;
        repeat (10) begin
            @(negedge Clock);
            cyc++;
        end
        drive(1, 1'b0, a, b);
        wait_ack(1, "drop_ack", cyc);
        chk("drop_lat",  cyc, 34);
        chk("drop_prod", bus.oProduct, 64'(a) * 64'(b));
        @(negedge Clock);
        chk("drop_ack1cyc", bus.oAck1, 1'b0);
        chk("drop_idle",    bus.oBusy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
